// File: rtl/decode_pkg.sv
// Shared constants, instruction-class encoding and the decoded-record type
// for the MIPS decode stage.
package decode_pkg;

  // Widest PC/target the record can carry; ADDR_W must not exceed this.
  localparam int unsigned DEC_AW_MAX = 32;

  // Primary opcodes (insn[31:26]).
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL function codes (insn[5:0]).
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_J       = 3'd2,
    CLS_NOP     = 3'd3,
    CLS_ILLEGAL = 3'd4
  } insn_class_e;

  typedef struct packed {
    logic [5:0]            opcode;
    logic [5:0]            func;
    logic [4:0]            rs;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic [4:0]            sa;
    logic [31:0]           imm;
    logic [DEC_AW_MAX-1:0] target;
    insn_class_e           cls;
    logic                  wr_en;
    logic [4:0]            wr_reg;
    logic [DEC_AW_MAX-1:0] pc;
  } decoded_t;

endpackage

// File: rtl/insn_decoder.sv
// Purely combinational MIPS decoder: one instruction word plus its PC in,
// one decoded record out.
module insn_decoder
  import decode_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [31:0]       insn_i,
  input  logic [ADDR_W-1:0] pc_i,
  output decoded_t          rec_o
);

  // Jump targets keep the upper PC bits above bit 27 of pc+4.
  localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

  logic [5:0]        op;
  logic [5:0]        fn;
  logic [4:0]        rs_f, rt_f, rd_f, sa_f;
  logic [31:0]       imm_sext, imm_zext, imm_lui;
  logic [ADDR_W-1:0] pc_plus4, br_off, br_tgt, j_tgt;
  logic              wr_en;
  logic [4:0]        dest;

  assign op       = insn_i[31:26];
  assign fn       = insn_i[5:0];
  assign rs_f     = insn_i[25:21];
  assign rt_f     = insn_i[20:16];
  assign rd_f     = insn_i[15:11];
  assign sa_f     = insn_i[10:6];
  assign imm_sext = {{16{insn_i[15]}}, insn_i[15:0]};
  assign imm_zext = {16'h0, insn_i[15:0]};
  assign imm_lui  = {insn_i[15:0], 16'h0};
  assign pc_plus4 = pc_i + ADDR_W'(4);
  assign br_off   = ADDR_W'($signed({insn_i[15:0], 2'b00}));
  assign br_tgt   = pc_plus4 + br_off;
  assign j_tgt    = (pc_plus4 & ~LOW28_MASK) | ADDR_W'({insn_i[25:0], 2'b00});

  // Classify the word and fill only the fields its class actually uses.
  always_comb begin
    rec_o        = '0;
    wr_en        = 1'b0;
    dest         = 5'd0;
    rec_o.opcode = op;
    rec_o.func   = fn;
    rec_o.pc     = DEC_AW_MAX'(pc_i);
    rec_o.cls    = CLS_ILLEGAL;
    if (insn_i == 32'd0) begin
      rec_o.cls = CLS_NOP;
    end else begin
      case (op)
        OP_SPECIAL: begin
          rec_o.cls = CLS_R;
          rec_o.rs  = rs_f;
          rec_o.rt  = rt_f;
          rec_o.rd  = rd_f;
          dest      = rd_f;
          case (fn)
            FN_SLL, FN_SRL, FN_SRA: begin
              rec_o.sa = sa_f;
              wr_en    = 1'b1;
            end
            FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_JR: wr_en = 1'b0;
            FN_SLLV, FN_SRLV, FN_SRAV, FN_JALR, FN_MFHI, FN_MFLO,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
            FN_NOR, FN_SLT, FN_SLTU: wr_en = 1'b1;
            default: begin
              rec_o.cls = CLS_ILLEGAL;
              rec_o.sa  = sa_f;
            end
          endcase
        end
        OP_J, OP_JAL: begin
          rec_o.cls    = CLS_J;
          rec_o.target = DEC_AW_MAX'(j_tgt);
          if (op == OP_JAL) begin
            wr_en = 1'b1;
            dest  = 5'd31;
          end
        end
        OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
          rec_o.cls    = CLS_I;
          rec_o.rs     = rs_f;
          rec_o.rt     = rt_f;
          rec_o.imm    = imm_sext;
          rec_o.target = DEC_AW_MAX'(br_tgt);
        end
        OP_ANDI, OP_ORI, OP_XORI: begin
          rec_o.cls = CLS_I;
          rec_o.rs  = rs_f;
          rec_o.rt  = rt_f;
          rec_o.imm = imm_zext;
          wr_en     = 1'b1;
          dest      = rt_f;
        end
        OP_LUI: begin
          rec_o.cls = CLS_I;
          rec_o.rs  = rs_f;
          rec_o.rt  = rt_f;
          rec_o.imm = imm_lui;
          wr_en     = 1'b1;
          dest      = rt_f;
        end
        OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LB, OP_LW, OP_LBU: begin
          rec_o.cls = CLS_I;
          rec_o.rs  = rs_f;
          rec_o.rt  = rt_f;
          rec_o.imm = imm_sext;
          wr_en     = 1'b1;
          dest      = rt_f;
        end
        OP_SB, OP_SW: begin
          rec_o.cls = CLS_I;
          rec_o.rs  = rs_f;
          rec_o.rt  = rt_f;
          rec_o.imm = imm_sext;
        end
        default: begin
          // Unknown opcode: register fields pass through untouched for debug.
          rec_o.cls = CLS_ILLEGAL;
          rec_o.rs  = rs_f;
          rec_o.rt  = rt_f;
          rec_o.rd  = rd_f;
          rec_o.sa  = sa_f;
        end
      endcase
    end
    rec_o.wr_en  = wr_en;
    rec_o.wr_reg = wr_en ? dest : 5'd0;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decoder feeding a DEPTH-entry FIFO with
// valid/ready on both sides, flush, and a count of retired decodes.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       insn,
  input  logic [ADDR_W-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode_out,
  output logic [5:0]        func_out,
  output logic [4:0]        rs_out,
  output logic [4:0]        rt_out,
  output logic [4:0]        rd_out,
  output logic [4:0]        sa_out,
  output logic [31:0]       imm_out,
  output logic [ADDR_W-1:0] target_out,
  output logic [2:0]        class_out,
  output logic              wr_en_out,
  output logic [4:0]        wr_reg_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [CNT_W-1:0]  decode_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_B = PTR_W + 1;

  decoded_t          dec_rec, head_rec, out_rec;
  decoded_t          mem_q [0:DEPTH-1];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_B-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic [CNT_W-1:0]  dcnt_q, dcnt_d;
  logic              push, pop;

  insn_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .insn_i (insn),
    .pc_i   (pc),
    .rec_o  (dec_rec)
  );

  // Flush beats any same-cycle push; a pop in the flush cycle still retires.
  assign in_ready  = ~full_q;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  // Next-state for pointers, occupancy, full flag and retire counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_B'(push) - CNT_B'(pop);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    full_d = (count_d == CNT_B'(DEPTH));
    dcnt_d = dcnt_q + CNT_W'(pop);
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= dec_rec;
  end

  // Control state, asynchronously cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      dcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      dcnt_q   <= dcnt_d;
    end
  end

  // Head is forced to zero when empty so stale RAM never reaches the outputs.
  assign head_rec = mem_q[rd_ptr_q];
  assign out_rec  = out_valid ? head_rec : decoded_t'('0);

  assign opcode_out   = out_rec.opcode;
  assign func_out     = out_rec.func;
  assign rs_out       = out_rec.rs;
  assign rt_out       = out_rec.rt;
  assign rd_out       = out_rec.rd;
  assign sa_out       = out_rec.sa;
  assign imm_out      = out_rec.imm;
  assign target_out   = out_rec.target[ADDR_W-1:0];
  assign class_out    = out_rec.cls;
  assign wr_en_out    = out_rec.wr_en;
  assign wr_reg_out   = out_rec.wr_reg;
  assign pc_out       = out_rec.pc[ADDR_W-1:0];
  assign decode_count = dcnt_q;

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined MIPS instruction-decode stage between fetch and register-read/execute. Each accepted instruction is decoded into fields, an instruction class, a sign- or zero-extended immediate, a destination register and a branch/jump target. Results are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides, and the FIFO contents can be discarded with a flush. Successor to the single-register decoder: it adds backpressure, buffering, flush, illegal-instruction detection and a retired-decode counter.

## Interface
- DEPTH, 2: FIFO entries; power of two, ≥2.
- ADDR_W, 32: PC and target width.
- CNT_W, 32: width of the decode counter.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; discards every buffered entry and any same-cycle input.
- in_valid / in_ready  in / out  1  upstream handshake.
- insn  in  32  instruction word.
- pc  in  ADDR_W  address of insn.
- out_valid / out_ready  out / in  1  downstream handshake.
- opcode_out, func_out  out  6  insn[31:26], insn[5:0].
- rs_out, rt_out, rd_out, sa_out  out  5  register fields; 0 where unused by the class.
- imm_out  out  32  extended immediate.
- target_out  out  ADDR_W  branch/jump target.
- class_out  out  3  R=0, I=1, J=2, NOP=3, ILLEGAL=4.
- wr_en_out  out  1  instruction writes a GPR.
- wr_reg_out  out  5  destination GPR; 0 when wr_en_out=0.
- pc_out  out  ADDR_W  PC of the head entry.
- decode_count  out  CNT_W  completed output handshakes.

## Operation
- Decode is combinational on insn. The decoded record is pushed into the FIFO on in_valid && in_ready && !flush. Outputs always show the FIFO head.
- insn==0: NOP class, wr_en=0.
- opcode 0: R class. Recognised funcs are ADD, ADDU, SUB, SUBU, MULT, MULTU, DIV, DIVU, MFHI, MFLO, SLT, SLTU, SLL, SLLV, SRL, SRLV, SRA, SRAV, AND, OR, XOR, NOR, JR, JALR. Any other func gives ILLEGAL.
  - sa_out is insn[10:6] only for SLL, SRL and SRA.
  - MULT, MULTU, DIV, DIVU and JR have wr_en=0.
  - JALR writes rd, with target = rs index unused (target_out=0).
  - Every other recognised func writes rd.
- I class opcodes: REGIMM 01, BEQ 04, BNE 05, BLEZ 06, BGTZ 07, ADDIU 09, SLTI 0A, SLTIU 0B, ANDI 0C, ORI 0D, XORI 0E, LUI 0F, LB 20, LW 23, LBU 24, SB 28, SW 2B.
  - imm: ANDI, ORI and XORI zero-extend. LUI gives {insn[15:0],16'h0}. All others sign-extend.
  - Branches: target = pc+4+(sext(imm)<<2), modulo 2^ADDR_W. wr_en=0.
  - Stores: wr_en=0.
  - All other I-class opcodes write rt.
- J class: J 02, JAL 03. target = {pc+4[ADDR_W-1:28], insn[25:0], 2'b00}. JAL writes reg 31.
- Any other opcode: ILLEGAL, wr_en=0, fields still passed through raw.
- decode_count increments on out_valid && out_ready and wraps at 2^CNT_W. It is cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous deassert handled by the external reset tree):
  - FIFO empty; out_valid=0, in_ready=1.
  - All data outputs 0; class_out=0; decode_count=0.
- Latency: an instruction accepted at edge N presents on the outputs after edge N, so out_valid is high in cycle N+1.
- Throughput: 1 instruction per cycle.
- in_ready = (count < DEPTH), a registered full flag. When full, there is no same-cycle pop-through: simultaneous push and pop is allowed only when not full.
- Data outputs are stable while out_valid && !out_ready.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Flush:
  - Next cycle count=0 and out_valid=0.
  - The same-cycle input is dropped, even though in_ready may read 1.
  - A same-cycle output handshake still increments decode_count.
- Reset asserted mid-stream discards all entries immediately.

## Structure
- decode_pkg holds the opcode and func constants, the class encoding, and the decoded-record struct: opcode, func, rs, rt, rd, sa, imm, target, class, wr_en, wr_reg, pc.
- The pure combinational decoder is a sub-module, insn_decoder, taking insn and pc and producing the record.
- decode_stage holds the FIFO storage, pointers, count, flush logic and counter.

## Test plan
- Reset, then push ADDU 0x00851021 at pc 0x100 with out_ready=1 -> next cycle: class=R, rs=4, rt=5, rd=2, wr_reg=2, out_valid=1; decode_count=1 a cycle later.
- Push ADDIU 0x2402FFFF, ORI 0x3402FFFF, LUI 0x3C021234 -> imm 0xFFFFFFFF, 0x0000FFFF, 0x12340000.
- Push BEQ 0x1000FFFF at pc 0x200 -> target 0x200, wr_en=0. Push JAL 0x0C000040 at pc 0x10000000 -> target 0x10000100, wr_reg=31.
- Hold out_ready=0 and push DEPTH+1 instructions -> in_ready falls after DEPTH accepts. Release -> entries drain in order with no loss or duplicate.
- Assert flush with 2 entries buffered and in_valid=1 -> next cycle out_valid=0, count=0, and the flushed-cycle instruction never appears.
- Push opcode 0x3F and func 0x3F (R-type) -> class=ILLEGAL, wr_en=0. Push insn 0 -> class=NOP.
